// File: rtl/milano_pkg.sv
// Milano core shared types: ALU operation encoding and EX stage state.
// Also holds small arithmetic helpers used by the execute stage.
package milano_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_opt_e;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_CALC,
    EX_DONE
  } ex_state_e;

  function automatic logic is_div_op(input alu_opt_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic [XLEN-1:0] abs_val(
    input logic [XLEN-1:0] v,
    input logic            sgn
  );
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/milano_divider.sv
// Milano 32-step restoring divider on magnitudes.
// Signs are applied at the end; divide-by-zero falls out naturally.
module milano_divider
  import milano_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [4:0]      cnt_q;
  logic            busy_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            rem_sel_q;

  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN:0]   rem_nx;

  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  assign rem_nx = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      quo_q     <= abs_val(dividend_i, signed_i);
      dvs_q     <= abs_val(divisor_i, signed_i);
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      rem_sel_q <= rem_i;
      // zero divisor keeps the all-ones quotient unsigned
      neg_q_q   <= signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1])
                   & (|divisor_i);
      neg_r_q   <= signed_i & dividend_i[XLEN-1];
    end else if (busy_q) begin
      rem_q <= rem_nx[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], ge};
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 5'd31);

  always_comb begin
    result_o = '0;
    if (rem_sel_q) result_o = neg_r_q ? -rem_q : rem_q;
    else           result_o = neg_q_q ? -quo_q : quo_q;
  end

endmodule

// File: rtl/ex_stage.sv
// Milano execute stage: single-cycle ALU plus iterative divider.
// Result is registered into the EX/WB boundary.
module ex_stage
  import milano_pkg::*;
#(
  parameter int DIV_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [4:0]      rd_addr_ex_i,
  input  logic            rd_wr_en_ex_i,
  input  logic [XLEN-1:0] operand_a_ex_i,
  input  logic [XLEN-1:0] operand_b_ex_i,
  input  alu_opt_e        alu_operate_ex_i,
  output logic            ex_busy_o,
  output logic [4:0]      rd_addr_wb_o,
  output logic            rd_wr_en_wb_o,
  output logic [XLEN-1:0] rd_wdata_wb_o
);

  localparam bit HAS_DIV = (DIV_EN != 0);

  ex_state_e       state_q;
  logic [4:0]      rd_q;
  logic            we_q;
  logic [XLEN-1:0] alu_res;
  logic            start;
  logic            div_done;
  logic [XLEN-1:0] div_res;
  logic [4:0]      shamt;

  assign shamt = operand_b_ex_i[4:0];
  assign start = HAS_DIV && (state_q == EX_IDLE) && !flush_i &&
                 is_div_op(alu_operate_ex_i);
  assign ex_busy_o = start || ((state_q == EX_CALC) && !flush_i);

  always_comb begin
    alu_res = '0;
    unique case (alu_operate_ex_i)
      ALU_ADD:  alu_res = operand_a_ex_i + operand_b_ex_i;
      ALU_SUB:  alu_res = operand_a_ex_i - operand_b_ex_i;
      ALU_AND:  alu_res = operand_a_ex_i & operand_b_ex_i;
      ALU_OR:   alu_res = operand_a_ex_i | operand_b_ex_i;
      ALU_XOR:  alu_res = operand_a_ex_i ^ operand_b_ex_i;
      ALU_SLL:  alu_res = operand_a_ex_i << shamt;
      ALU_SRL:  alu_res = operand_a_ex_i >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(operand_a_ex_i) >>> shamt);
      ALU_SLT:  alu_res = {31'b0, $signed(operand_a_ex_i) <
                                  $signed(operand_b_ex_i)};
      ALU_SLTU: alu_res = {31'b0, operand_a_ex_i < operand_b_ex_i};
      default:  alu_res = '0;
    endcase
  end

  generate
    if (HAS_DIV) begin : g_div
      logic div_busy;
      milano_divider u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .kill_i     (flush_i),
        .start_i    (start),
        .signed_i   ((alu_operate_ex_i == ALU_DIV) ||
                     (alu_operate_ex_i == ALU_REM)),
        .rem_i      ((alu_operate_ex_i == ALU_REM) ||
                     (alu_operate_ex_i == ALU_REMU)),
        .dividend_i (operand_a_ex_i),
        .divisor_i  (operand_b_ex_i),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .result_o   (div_res)
      );
    end else begin : g_nodiv
      assign div_done = 1'b0;
      assign div_res  = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= EX_IDLE;
      rd_q          <= '0;
      we_q          <= 1'b0;
      rd_addr_wb_o  <= '0;
      rd_wr_en_wb_o <= 1'b0;
      rd_wdata_wb_o <= '0;
    end else if (flush_i) begin
      state_q       <= EX_IDLE;
      rd_addr_wb_o  <= '0;
      rd_wr_en_wb_o <= 1'b0;
      rd_wdata_wb_o <= '0;
    end else begin
      unique case (state_q)
        EX_IDLE: begin
          if (start) begin
            state_q       <= EX_CALC;
            rd_q          <= rd_addr_ex_i;
            we_q          <= rd_wr_en_ex_i;
            rd_addr_wb_o  <= '0;
            rd_wr_en_wb_o <= 1'b0;
            rd_wdata_wb_o <= '0;
          end else begin
            rd_addr_wb_o  <= rd_addr_ex_i;
            rd_wr_en_wb_o <= rd_wr_en_ex_i &&
                             (alu_operate_ex_i != ALU_NONE);
            rd_wdata_wb_o <= alu_res;
          end
        end
        EX_CALC: begin
          rd_addr_wb_o  <= '0;
          rd_wr_en_wb_o <= 1'b0;
          rd_wdata_wb_o <= '0;
          if (div_done) state_q <= EX_DONE;
        end
        EX_DONE: begin
          rd_addr_wb_o  <= rd_q;
          rd_wr_en_wb_o <= we_q;
          rd_wdata_wb_o <= div_res;
          state_q       <= EX_IDLE;
        end
        default: state_q <= EX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for the Milano execute stage.
// Covers ALU ops, divide latency and corners, flush and async reset.
module tb_ex_stage;
  import milano_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [4:0]  rd_addr_ex_i;
  logic        rd_wr_en_ex_i;
  logic [31:0] operand_a_ex_i;
  logic [31:0] operand_b_ex_i;
  alu_opt_e    alu_operate_ex_i;
  logic        ex_busy_o;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_wr_en_wb_o;
  logic [31:0] rd_wdata_wb_o;

  int errs   = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  ex_stage #(.DIV_EN(1)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .rd_addr_ex_i     (rd_addr_ex_i),
    .rd_wr_en_ex_i    (rd_wr_en_ex_i),
    .operand_a_ex_i   (operand_a_ex_i),
    .operand_b_ex_i   (operand_b_ex_i),
    .alu_operate_ex_i (alu_operate_ex_i),
    .ex_busy_o        (ex_busy_o),
    .rd_addr_wb_o     (rd_addr_wb_o),
    .rd_wr_en_wb_o    (rd_wr_en_wb_o),
    .rd_wdata_wb_o    (rd_wdata_wb_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_opt_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic we);
    alu_operate_ex_i = op;
    operand_a_ex_i   = a;
    operand_b_ex_i   = b;
    rd_addr_ex_i     = rd;
    rd_wr_en_ex_i    = we;
  endtask

  task automatic alu_t(input string tag, input alu_opt_e op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    drive(op, a, b, rd, 1'b1);
    #1 chk({tag, "_busy"}, 32'(ex_busy_o), 32'd0);
    @(posedge clk_i); #1;
    chk({tag, "_data"}, rd_wdata_wb_o, exp);
    chk({tag, "_rd"}, 32'(rd_addr_wb_o), 32'(rd));
    chk({tag, "_we"}, 32'(rd_wr_en_wb_o), 32'd1);
  endtask

  task automatic div_t(input string tag, input alu_opt_e op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    drive(op, a, b, rd, 1'b1);
    #1;
    while (ex_busy_o && n < 40) begin
      n++;
      @(posedge clk_i); #1;
      if (rd_wr_en_wb_o) bad++;
    end
    chk({tag, "_busycyc"}, 32'(n), 32'd33);
    chk({tag, "_bubble"}, 32'(bad), 32'd0);
    @(posedge clk_i); #1;
    chk({tag, "_data"}, rd_wdata_wb_o, exp);
    chk({tag, "_rd"}, 32'(rd_addr_wb_o), 32'(rd));
    chk({tag, "_we"}, 32'(rd_wr_en_wb_o), 32'd1);
  endtask

  task automatic quiet_t(input string tag, input int cycles);
    int w;
    w = 0;
    drive(ALU_NONE, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (cycles) begin
      @(posedge clk_i); #1;
      if (rd_wr_en_wb_o || ex_busy_o) w++;
    end
    chk(tag, 32'(w), 32'd0);
  endtask

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd1, 5'd1, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_data", rd_wdata_wb_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_wb_o), 32'd0);
    chk("rst_we", 32'(rd_wr_en_wb_o), 32'd0);
    chk("rst_busy", 32'(ex_busy_o), 32'd0);
    drive(ALU_NONE, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    alu_t("add", ALU_ADD, 32'd5, 32'd7, 5'd3, 32'd12);
    alu_t("sub", ALU_SUB, 32'd0, 32'd1, 5'd4, 32'hFFFF_FFFF);
    alu_t("sra", ALU_SRA, 32'h8000_0000, 32'h24, 5'd5, 32'hF800_0000);
    alu_t("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1);
    alu_t("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd0);
    alu_t("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd8, 32'h00F0_1200);
    alu_t("or", ALU_OR, 32'hF000_0001, 32'h0000_0F00, 5'd9, 32'hF000_0F01);
    alu_t("xor", ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd10, 32'h5555_5555);
    alu_t("sll", ALU_SLL, 32'h0000_0003, 32'h21, 5'd11, 32'h0000_0006);
    alu_t("srl", ALU_SRL, 32'h8000_0000, 32'd31, 5'd12, 32'd1);
    alu_t("x0", ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd5);

    drive(ALU_NONE, 32'd9, 32'd9, 5'd2, 1'b1);
    @(posedge clk_i); #1;
    chk("none_we", 32'(rd_wr_en_wb_o), 32'd0);

    div_t("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
    div_t("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);
    div_t("divu0", ALU_DIVU, 32'd9, 32'd0, 5'd13, 32'hFFFF_FFFF);
    div_t("remu0", ALU_REMU, 32'd9, 32'd0, 5'd14, 32'd9);
    div_t("div0s", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFFF);
    div_t("rem0s", ALU_REM, 32'hFFFF_FFF9, 32'd0, 5'd16, 32'hFFFF_FFF9);
    div_t("ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
    div_t("ovfrem", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
    div_t("divu", ALU_DIVU, 32'hFFFF_FFFE, 32'd3, 5'd19, 32'h5555_5554);

    // back-to-back divides, then an ADD one edge after
    div_t("b2b1", ALU_DIV, 32'd100, 32'd7, 5'd20, 32'd14);
    div_t("b2b2", ALU_DIV, 32'hFFFF_FF9C, 32'd7, 5'd21, 32'hFFFF_FFF2);
    alu_t("b2badd", ALU_ADD, 32'd40, 32'd2, 5'd22, 32'd42);
    quiet_t("b2b_quiet", 4);

    drive(ALU_DIV, 32'd50, 32'd3, 5'd23, 1'b1);
    repeat (11) @(posedge clk_i);
    #1 flush_i = 1'b1;
    #1 chk("flush_busy", 32'(ex_busy_o), 32'd0);
    @(posedge clk_i); #1;
    chk("flush_we", 32'(rd_wr_en_wb_o), 32'd0);
    flush_i = 1'b0;
    quiet_t("flush_nowrite", 40);
    alu_t("postflush", ALU_SUB, 32'd10, 32'd3, 5'd24, 32'd7);

    drive(ALU_DIV, 32'd1000, 32'd3, 5'd25, 1'b1);
    repeat (6) @(posedge clk_i);
    #1;
    drive(ALU_NONE, 32'd0, 32'd0, 5'd0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("mrst_data", rd_wdata_wb_o, 32'd0);
    chk("mrst_rd", 32'(rd_addr_wb_o), 32'd0);
    chk("mrst_we", 32'(rd_wr_en_wb_o), 32'd0);
    chk("mrst_busy", 32'(ex_busy_o), 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    alu_t("postrst", ALU_ADD, 32'd1, 32'd2, 5'd26, 32'd3);
    quiet_t("rst_nowrite", 40);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
